// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer for the SPI slave: collects WIDTH MOSI bits while enabled,
// then presents the word on StoP_out with a one-cycle finish pulse.
module serial_to_parallel #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MOSI,
  input  logic             enable,
  output logic [WIDTH-1:0] StoP_out,
  output logic             finish
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nx;
  logic [CW-1:0]    cnt_q;

  // Shift expressed arithmetically so WIDTH=1 needs no special-case slicing.
  always_comb begin
    if (MSB_FIRST)
      shift_nx = (shift_q << 1) | WIDTH'(MOSI);
    else
      shift_nx = (shift_q >> 1) | (WIDTH'(MOSI) << (WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      StoP_out <= '0;
      finish   <= 1'b0;
    end else if (!enable) begin
      shift_q <= '0;
      cnt_q   <= '0;
      finish  <= 1'b0;
    end else begin
      shift_q <= shift_nx;
      if (cnt_q == LAST) begin
        // Word completes on this edge, including the bit sampled now.
        cnt_q    <= '0;
        StoP_out <= shift_nx;
        finish   <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
        finish <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench: MSB-first and LSB-first instances share one stimulus stream and are
// compared every cycle against a bit-queue reference model, plus directed word checks.
module tb_serial_to_parallel;

  logic       clk = 1'b0;
  logic       rst;
  logic       mosi;
  logic       enable;
  logic [7:0] out_m, out_l;
  logic       fin_m, fin_l;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         bits_q[$];
  logic [7:0] exp_m, exp_l;
  logic       exp_fin;

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .MOSI(mosi), .enable(enable), .StoP_out(out_m), .finish(fin_m));

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .MOSI(mosi), .enable(enable), .StoP_out(out_l), .finish(fin_l));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // i-th received bit lands at weight 2^(7-i) when MSB first, 2^i when LSB first
  function automatic logic [7:0] assemble(input bit msb_first);
    int v = 0;
    for (int i = 0; i < 8; i++)
      if (bits_q[i] != 0) v += msb_first ? (1 << (7 - i)) : (1 << i);
    return 8'(v);
  endfunction

  task automatic model_reset();
    bits_q.delete();
    exp_m   = 8'h00;
    exp_l   = 8'h00;
    exp_fin = 1'b0;
  endtask

  task automatic compare_all();
    chk("msb_out", 32'(out_m), 32'(exp_m));
    chk("lsb_out", 32'(out_l), 32'(exp_l));
    chk("msb_fin", 32'(fin_m), 32'(exp_fin));
    chk("lsb_fin", 32'(fin_l), 32'(exp_fin));
  endtask

  // drive one cycle from the negedge, update model at posedge, compare at next negedge
  task automatic cycle(input logic en, input logic b);
    enable = en;
    mosi   = b;
    @(posedge clk);
    if (en) begin
      bits_q.push_back(int'(b));
      if (bits_q.size() == 8) begin
        exp_m   = assemble(1'b1);
        exp_l   = assemble(1'b0);
        exp_fin = 1'b1;
        bits_q.delete();
      end else begin
        exp_fin = 1'b0;
      end
    end else begin
      bits_q.delete();
      exp_fin = 1'b0;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) cycle(1'b1, w[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; mosi = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_out", 32'(out_m), 32'h0);
    rst = 1'b0;

    // single word, both bit orders (0xA5 is a bit palindrome)
    send_word(8'hA5);
    chk("a5_msb", 32'(out_m), 32'hA5);
    chk("a5_lsb", 32'(out_l), 32'hA5);
    chk("a5_fin", 32'(fin_m), 32'h1);
    cycle(1'b0, 1'b0);
    chk("a5_fin_drop", 32'(fin_m), 32'h0);

    // 1,0,0,0,0,0,0,0 -> 0x80 MSB first, 0x01 LSB first
    send_word(8'h80);
    chk("w80_msb", 32'(out_m), 32'h80);
    chk("w01_lsb", 32'(out_l), 32'h01);

    // back-to-back, no dead cycle between words
    send_word(8'h3C);
    chk("b2b_3c", 32'(out_m), 32'h3C);
    chk("b2b_fin1", 32'(fin_m), 32'h1);
    send_word(8'hFF);
    chk("b2b_ff", 32'(out_m), 32'hFF);
    chk("b2b_fin2", 32'(fin_m), 32'h1);

    // abort: 5 bits, 2 idle, then 0x81
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("abort_hold", 32'(out_m), 32'hFF);
    send_word(8'h81);
    chk("abort_81", 32'(out_m), 32'h81);
    chk("abort_fin", 32'(fin_m), 32'h1);

    // idle hold with random MOSI
    send_word(8'h5A);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'($urandom));
    chk("idle_5a", 32'(out_m), 32'h5A);
    chk("idle_fin", 32'(fin_m), 32'h0);

    // asynchronous reset while finish is high and enable stays 1
    send_word(8'hC3);
    chk("pre_rst_fin", 32'(fin_m), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_m", 32'(out_m), 32'h0);
    chk("arst_out_l", 32'(out_l), 32'h0);
    chk("arst_fin", 32'(fin_m), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1);
      chk("post_rst_nofin", 32'(fin_m), 32'h0);
    end
    cycle(1'b1, 1'b0);
    chk("post_rst_fe", 32'(out_m), 32'hFE);
    chk("post_rst_7f", 32'(out_l), 32'h7F);

    // random stimulus against the model, with occasional enable drops
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) != 0), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
